// File: rtl/unified_mem_port.sv
// Shared single-ported word RAM serving an instruction-fetch port and a data port.
// Data wins arbitration unless fetch has been starved STARVE_MAX grant slots in a row.
module unified_mem_port #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH      = 256,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int SW    = $clog2(STARVE_MAX + 1);

    typedef enum logic {IDLE, RD_BUSY} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              owner_q, owner_d;
    logic [DATA_W-1:0] buf_q;
    logic              if_rvalid_q, d_rvalid_q, d_err_q;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              grant_ok, fetch_win;
    logic              d_mis, d_rd_acc, d_wr_acc, err_acc, rd_acc, deliver;
    logic [IDX_W-1:0]  rd_idx, d_idx;
    logic [DATA_W-1:0] rd_word, deliver_data;
    logic              unused_addr;

    // Upper address bits alias and fetch byte offset is don't-care.
    assign unused_addr = ^{if_addr[ADDR_W-1:IDX_W+2], if_addr[1:0], d_addr[ADDR_W-1:IDX_W+2]};

    // Output process: combinational grant. Accept = req && ready in the same cycle.
    always_comb begin
        grant_ok  = (state_q == IDLE) || (cnt_q == 3'd1);
        fetch_win = if_req && (!d_req || (starve_q == SW'(STARVE_MAX)));
        if_ready  = reset && grant_ok && fetch_win;
        d_ready   = reset && grant_ok && d_req && !fetch_win;
    end

    always_comb begin
        d_mis    = (d_addr[1:0] != 2'b00);
        d_rd_acc = d_ready && !d_we && !d_mis;
        d_wr_acc = d_ready && d_we && !d_mis;
        err_acc  = d_ready && d_mis;
        rd_acc   = if_ready || d_rd_acc;
        d_idx    = d_addr[IDX_W+1:2];
        rd_idx   = if_ready ? if_addr[IDX_W+1:2] : d_idx;
        rd_word  = mem_q[rd_idx];
    end

    // Next-state process; cnt holds the cycles left until rvalid, 1 meaning "this cycle".
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        if (rd_acc) begin
            state_d = RD_BUSY;
            cnt_d   = 3'(RD_LAT);
            owner_d = if_ready;
        end else if (state_q == RD_BUSY) begin
            if (cnt_q == 3'd1) begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
        end else begin
            cnt_d = 3'd0;
        end
        if (if_ready) begin
            starve_d = '0;
        end else if (grant_ok && if_req && (starve_q != SW'(STARVE_MAX))) begin
            starve_d = starve_q + SW'(1);
        end
        deliver      = (state_d == RD_BUSY) && (cnt_d == 3'd1);
        deliver_data = rd_acc ? rd_word : buf_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            starve_q    <= '0;
            owner_q     <= 1'b0;
            buf_q       <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            d_err_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            owner_q     <= owner_d;
            buf_q       <= rd_acc ? rd_word : buf_q;
            if_rvalid_q <= deliver && owner_d;
            d_rvalid_q  <= deliver && !owner_d;
            d_err_q     <= err_acc;
            if (deliver && owner_d) begin
                if_rdata_q <= deliver_data;
            end
            if (deliver && !owner_d) begin
                d_rdata_q <= deliver_data;
            end
        end
    end

    // Memory keeps its contents across reset; d_ready is already gated by reset.
    always_ff @(posedge clk) begin
        if (d_wr_acc) begin
            for (int i = 0; i < NB; i++) begin
                if (d_be[i]) begin
                    mem_q[d_idx][8*i +: 8] <= d_wdata[8*i +: 8];
                end
            end
        end
    end

    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;

endmodule

// File: tb/tb_unified_mem_port.sv
// Directed bench for unified_mem_port: three instances with RD_LAT 1, 3 and 4,
// a word model per instance and queues of expected read data, due cycles and error pulses.
module tb_unified_mem_port;

    logic        clk = 1'b0;
    logic        rst_n     [3];
    logic        if_req    [3];
    logic [31:0] if_addr   [3];
    logic        if_ready  [3];
    logic        if_rvalid [3];
    logic [31:0] if_rdata  [3];
    logic        d_req     [3];
    logic        d_we      [3];
    logic [3:0]  d_be      [3];
    logic [31:0] d_addr    [3];
    logic [31:0] d_wdata   [3];
    logic        d_ready   [3];
    logic        d_rvalid  [3];
    logic [31:0] d_rdata   [3];
    logic        d_err     [3];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] model [3][256];
    logic [31:0] d_exp_q[$];
    int          d_due_q[$];
    logic [31:0] if_exp_q[$];
    int          if_due_q[$];
    int          err_due_q[$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        unified_mem_port #(
            .RD_LAT(g == 0 ? 1 : (g == 1 ? 3 : 4))
        ) u_dut (
            .clk      (clk),
            .reset    (rst_n[g]),
            .if_req   (if_req[g]),
            .if_addr  (if_addr[g]),
            .if_ready (if_ready[g]),
            .if_rvalid(if_rvalid[g]),
            .if_rdata (if_rdata[g]),
            .d_req    (d_req[g]),
            .d_we     (d_we[g]),
            .d_be     (d_be[g]),
            .d_addr   (d_addr[g]),
            .d_wdata  (d_wdata[g]),
            .d_ready  (d_ready[g]),
            .d_rvalid (d_rvalid[g]),
            .d_rdata  (d_rdata[g]),
            .d_err    (d_err[g])
        );
    end

    // ---------------- clock ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic int lat_of(input int s);
        return (s == 0) ? 1 : ((s == 1) ? 3 : 4);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic d_op(input int s, input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wd, input bit expect_rsp, output int acc_cyc);
        int n;
        logic [31:0] w;
        n = 0;
        d_req[s] = 1'b1; d_we[s] = we; d_be[s] = be; d_addr[s] = addr; d_wdata[s] = wd;
        #1;
        while (d_ready[s] !== 1'b1 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        chk("d_ready_timeout", 32'(n < 50), 32'd1);
        acc_cyc = cyc;
        if (n < 50) begin
            if (addr[1:0] != 2'b00) begin
                err_due_q.push_back(cyc + 1);
            end else if (we) begin
                w = model[s][addr[9:2]];
                for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
                model[s][addr[9:2]] = w;
            end else if (expect_rsp) begin
                d_exp_q.push_back(model[s][addr[9:2]]);
                d_due_q.push_back(cyc + lat_of(s));
            end
        end
        @(negedge clk);
        d_req[s] = 1'b0;
    endtask

    task automatic f_op(input int s, input logic [31:0] addr, output int acc_cyc);
        int n;
        n = 0;
        if_req[s] = 1'b1; if_addr[s] = addr;
        #1;
        while (if_ready[s] !== 1'b1 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        chk("if_ready_timeout", 32'(n < 50), 32'd1);
        acc_cyc = cyc;
        if (n < 50) begin
            if_exp_q.push_back(model[s][addr[9:2]]);
            if_due_q.push_back(cyc + lat_of(s));
        end
        @(negedge clk);
        if_req[s] = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (d_rvalid[g] === 1'b1) begin
                if (d_exp_q.size() == 0) chk("d_rvalid_unexpected", 32'(d_rvalid[g]), 32'd0);
                else begin
                    chk("d_rdata", d_rdata[g], d_exp_q.pop_front());
                    chk("d_rvalid_cycle", cyc, d_due_q.pop_front());
                end
            end
            if (if_rvalid[g] === 1'b1) begin
                if (if_exp_q.size() == 0) chk("if_rvalid_unexpected", 32'(if_rvalid[g]), 32'd0);
                else begin
                    chk("if_rdata", if_rdata[g], if_exp_q.pop_front());
                    chk("if_rvalid_cycle", cyc, if_due_q.pop_front());
                end
            end
            if (d_err[g] === 1'b1) begin
                if (err_due_q.size() == 0) chk("d_err_unexpected", 32'(d_err[g]), 32'd0);
                else chk("d_err_cycle", cyc, err_due_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int ac, ac0, ac1, start;
        for (int g = 0; g < 3; g++) begin
            rst_n[g] = 1'b0; if_req[g] = 1'b1; if_addr[g] = '0;
            d_req[g] = 1'b1; d_we[g] = 1'b0; d_be[g] = 4'hF; d_addr[g] = '0; d_wdata[g] = '0;
        end
        repeat (2) @(negedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            chk("rst_if_ready", 32'(if_ready[g]), 32'd0);
            chk("rst_d_ready", 32'(d_ready[g]), 32'd0);
        end
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            rst_n[g] = 1'b1; if_req[g] = 1'b0; d_req[g] = 1'b0;
        end
        #1;
        for (int g = 0; g < 3; g++) begin
            chk("rst_if_rvalid", 32'(if_rvalid[g]), 32'd0);
            chk("rst_d_rvalid", 32'(d_rvalid[g]), 32'd0);
            chk("rst_d_err", 32'(d_err[g]), 32'd0);
            chk("rst_if_rdata", if_rdata[g], 32'd0);
            chk("rst_d_rdata", d_rdata[g], 32'd0);
        end
        @(negedge clk);

        // Write then fetch the same word; fetch with aliased, unaligned address.
        d_op(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, ac);
        start = cyc;
        f_op(0, 32'h10, ac);
        chk("if_ready_cycle0", ac, start);
        f_op(0, 32'h412, ac);

        // Byte-enabled write.
        d_op(0, 1'b1, 4'hF, 32'h20, 32'h11223344, 1'b0, ac);
        d_op(0, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, 1'b0, ac);
        d_op(0, 1'b0, 4'h0, 32'h20, 32'h0, 1'b1, ac);
        repeat (2) @(negedge clk);

        // Contention: both requesters held high, continuous data reads.
        if_req[0] = 1'b1; if_addr[0] = 32'h20;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h10;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("arb_fetch_slot", 32'(if_ready[0]), (i % 4 == 3) ? 32'd1 : 32'd0);
            chk("arb_data_slot", 32'(d_ready[0]), (i % 4 == 3) ? 32'd0 : 32'd1);
            if (if_ready[0] === 1'b1) begin
                if_exp_q.push_back(model[0][8'h08]); if_due_q.push_back(cyc + 1);
            end
            if (d_ready[0] === 1'b1) begin
                d_exp_q.push_back(model[0][8'h04]); d_due_q.push_back(cyc + 1);
            end
            @(negedge clk);
        end
        if_req[0] = 1'b0; d_req[0] = 1'b0;
        repeat (2) @(negedge clk);

        // RD_LAT=3 back-to-back reads.
        d_op(1, 1'b1, 4'hF, 32'h0, 32'h0BADCAFE, 1'b0, ac);
        d_op(1, 1'b1, 4'hF, 32'h4, 32'h12345678, 1'b0, ac);
        d_op(1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, ac0);
        d_op(1, 1'b0, 4'h0, 32'h4, 32'h0, 1'b1, ac1);
        chk("b2b_second_ready_cycle", ac1, ac0 + 3);
        repeat (6) @(negedge clk);

        // Misaligned read and write: error pulse, no access.
        start = cyc;
        d_op(0, 1'b0, 4'h0, 32'h13, 32'h0, 1'b1, ac);
        chk("mis_ready_cycle", ac, start);
        d_op(0, 1'b1, 4'hF, 32'h12, 32'h0, 1'b0, ac);
        d_op(0, 1'b0, 4'h0, 32'h10, 32'h0, 1'b1, ac);
        repeat (3) @(negedge clk);

        // RD_LAT=4 read cancelled by reset one cycle after accept.
        d_op(2, 1'b1, 4'hF, 32'h40, 32'hCAFEF00D, 1'b0, ac);
        d_op(2, 1'b0, 4'h0, 32'h40, 32'h0, 1'b0, ac);
        rst_n[2] = 1'b0; d_req[2] = 1'b1; d_we[2] = 1'b0; d_addr[2] = 32'h40;
        #1;
        chk("rst_forces_d_ready_low", 32'(d_ready[2]), 32'd0);
        @(negedge clk);
        rst_n[2] = 1'b1; d_req[2] = 1'b0;
        repeat (8) @(negedge clk);
        chk("post_rst_d_rdata", d_rdata[2], 32'd0);
        d_op(2, 1'b0, 4'h0, 32'h40, 32'h0, 1'b1, ac);
        repeat (8) @(negedge clk);

        chk("d_queue_drained", 32'(d_exp_q.size()), 32'd0);
        chk("if_queue_drained", 32'(if_exp_q.size()), 32'd0);
        chk("err_queue_drained", 32'(err_due_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unified_mem_port.md
Name: unified_mem_port

Overview:
- Parametrised shared-memory subsystem for the next-generation core.
- Replaces the separate instruction and data memories with one single-ported word RAM.
- Arbitrates between an instruction-fetch port and a data port with a req/ready/rvalid handshake.
- Supports configurable read latency and byte-enabled writes; the core stalls on the ready/rvalid signals.

Parameters:
- DATA_W, 32: word width in bits; must be a multiple of 8.
- ADDR_W, 32: byte-address width on both ports.
- DEPTH, 256: number of words; power of 2.
- RD_LAT, 1: read latency in cycles, legal range 1..4.
- STARVE_MAX, 3: maximum consecutive fetch denials before fetch is forced to win.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch byte address.
- if_ready  out  1  fetch accepted this cycle.
- if_rvalid  out  1  fetch data valid (1-cycle pulse).
- if_rdata  out  DATA_W  fetch data.
- d_req  in  1  data request.
- d_we  in  1  1 = write, 0 = read.
- d_be  in  DATA_W/8  byte enables for writes.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  write data.
- d_ready  out  1  data request accepted this cycle.
- d_rvalid  out  1  read data valid (1-cycle pulse).
- d_rdata  out  DATA_W  read data.
- d_err  out  1  1-cycle pulse: misaligned data address rejected.

Behaviour:
- Word index = addr[log2(DEPTH)+1:2]; upper address bits are ignored (aliasing).
- Fetch addr[1:0] is ignored.
- FSM states:
  - IDLE: port free.
  - RD_BUSY: read outstanding; counter cnt runs RD_LAT down to 1.
- Grant is combinational and only in IDLE, or in the RD_BUSY cycle where cnt==1 (back-to-back reads).
- Arbitration:
  - Data has priority by default.
  - Fetch wins only if d_req is low, or if starve_cnt == STARVE_MAX.
  - starve_cnt increments on each cycle fetch is denied while if_req is high and a grant was possible.
  - starve_cnt clears on fetch grant, saturates at STARVE_MAX, and never wraps.
- Accept means req && ready in the same cycle; at most one of if_ready/d_ready is high in a cycle.
- Write accept (d_we=1, aligned):
  - Bytes with d_be[i]=1 are updated at that edge; other bytes are unchanged.
  - No rvalid pulse; the FSM stays/returns IDLE, so the next request can be granted the next cycle.
- Read accept:
  - RAM is sampled at the accept edge, so the read returns pre-write data if a write was accepted in that same cycle (impossible, single grant).
  - The matching rvalid pulses exactly RD_LAT cycles after the accept cycle.
  - rdata is held stable until the next rvalid; it is not cleared after the pulse.
- Misaligned data access (d_addr[1:0]!=0):
  - d_ready=1 (consumed) and d_err pulses the next cycle.
  - No memory access and no rvalid.
  - Counts as a data grant for arbitration.
- Requesters must hold req/addr/wdata stable until ready; changing them before ready is undefined.
- Reset low at an edge:
  - State → IDLE; cnt, starve_cnt, all rvalid and d_err → 0; if_rdata and d_rdata → 0.
  - An outstanding read is cancelled and produces no rvalid.
  - Memory contents are preserved.
  - if_ready and d_ready are forced 0 while reset is low.
- No initialisation from file inside this block; the bench preloads through the write port.

Test Plan:
- Reset, then data write addr 0x10, be=1111, wdata 0xDEADBEEF; fetch addr 0x10 (RD_LAT=1) → if_ready in cycle 0, if_rvalid in cycle 1 with if_rdata=0xDEADBEEF.
- Byte enable: word 0x20 = 0x11223344; write be=0101, wdata 0xAABBCCDD; read → d_rdata=0x11BB33DD.
- Contention with STARVE_MAX=3: d_req and if_req both held high, continuous data reads (RD_LAT=1) → data granted in 3 consecutive grant slots, fetch in the 4th, then starve_cnt restarts from 0.
- RD_LAT=3 back-to-back reads of 0x0, 0x4 → d_rvalid at cycles 3 and 6; d_ready high in cycle 3 for the second read; no overlap.
- Misaligned data read addr 0x13 → d_ready=1, d_err=1 next cycle, no d_rvalid, memory unchanged.
- Reset low 1 cycle after a RD_LAT=4 read accept → no d_rvalid ever appears; after release, re-read returns the previously written data.
